exc_commit_ctrl: RTL and testbench

Exception/ertn commit sequencer between the write-back stage and the CSR file. It collects per-instruction exception flags and the pending-interrupt indication at commit, then picks one cause by fixed priority. It drives the CSR file's exception/ertn update strobes and issues a single pipeline redirect. It then holds a flush for a configurable drain window so in-flight fetches and younger instructions cannot commit.

---
 rtl/exc_commit_ctrl_if.sv | 39 +++
 rtl/exc_commit_ctrl.sv | 126 ++++++++++++
 tb/tb_exc_commit_ctrl.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/exc_commit_ctrl_if.sv
// rtl/exc_commit_ctrl_if.sv - commit-side bundle between WB stage, CSR file and exc_commit_ctrl
interface exc_commit_ctrl_if;
  logic        ws_valid;
  logic [31:0] ws_pc;
  logic        ws_ex_adef;
  logic        ws_ex_ine;
  logic        ws_ex_sys;
  logic        ws_ex_brk;
  logic        ws_ex_ale;
  logic [31:0] ws_vaddr;
  logic        ws_ertn;
  logic        has_int;
  logic [31:0] csr_eentry;
  logic [31:0] csr_era;
  logic        wb_ex;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_pc;
  logic [31:0] wb_vaddr;
  logic        ertn_flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush_all;
  logic        ws_commit_ok;

  modport master (
    output ws_valid, ws_pc, ws_ex_adef, ws_ex_ine, ws_ex_sys, ws_ex_brk, ws_ex_ale,
           ws_vaddr, ws_ertn, has_int, csr_eentry, csr_era,
    input  wb_ex, wb_ecode, wb_esubcode, wb_pc, wb_vaddr, ertn_flush,
           redirect_valid, redirect_pc, flush_all, ws_commit_ok
  );

  modport slave (
    input  ws_valid, ws_pc, ws_ex_adef, ws_ex_ine, ws_ex_sys, ws_ex_brk, ws_ex_ale,
           ws_vaddr, ws_ertn, has_int, csr_eentry, csr_era,
    output wb_ex, wb_ecode, wb_esubcode, wb_pc, wb_vaddr, ertn_flush,
           redirect_valid, redirect_pc, flush_all, ws_commit_ok
  );
endinterface

// File: rtl/exc_commit_ctrl.sv
// rtl/exc_commit_ctrl.sv - exception/ertn commit sequencer with drain window; EXC_PERF_CNT_EN adds event counters
module exc_commit_ctrl #(
  parameter int DRAIN_CYCLES = 2
) (
  input  logic               clk,
  input  logic               resetn,
  exc_commit_ctrl_if.slave   bus
`ifdef EXC_PERF_CNT_EN
  ,
  output logic [31:0]        exc_cnt,
  output logic [31:0]        ertn_cnt
`endif
);

  typedef enum logic {IDLE, DRAIN} state_t;

  localparam logic [3:0] DRAIN_LD = 4'(DRAIN_CYCLES);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  logic        cause_vld;
  logic [5:0]  cause_ecode;
  logic [31:0] cause_vaddr;
  logic        commit_ex;
  logic        commit_ertn;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Fixed priority: interrupt first, then the oldest-stage exception source.
  always_comb begin
    cause_vld   = 1'b1;
    cause_ecode = 6'h00;
    cause_vaddr = 32'd0;
    if (bus.has_int) begin
      cause_ecode = 6'h00;
    end else if (bus.ws_ex_adef) begin
      cause_ecode = 6'h08;
      cause_vaddr = bus.ws_pc;
    end else if (bus.ws_ex_ine) begin
      cause_ecode = 6'h0D;
    end else if (bus.ws_ex_sys) begin
      cause_ecode = 6'h0B;
    end else if (bus.ws_ex_brk) begin
      cause_ecode = 6'h0C;
    end else if (bus.ws_ex_ale) begin
      cause_ecode = 6'h09;
      cause_vaddr = bus.ws_vaddr;
    end else begin
      cause_vld   = 1'b0;
    end
  end

  assign commit_ex   = (state_q == IDLE) && bus.ws_valid && cause_vld;
  assign commit_ertn = (state_q == IDLE) && bus.ws_valid && !cause_vld && bus.ws_ertn;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (commit_ex || commit_ertn) begin
          state_d = DRAIN;
          cnt_d   = DRAIN_LD;
        end
      end
      DRAIN: begin
        if (cnt_q <= 4'd1) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d   = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_comb begin
    bus.wb_ex          = commit_ex;
    bus.wb_ecode       = commit_ex ? cause_ecode : 6'h00;
    bus.wb_esubcode    = 9'd0;
    bus.wb_pc          = commit_ex ? bus.ws_pc : 32'd0;
    bus.wb_vaddr       = commit_ex ? cause_vaddr : 32'd0;
    bus.ertn_flush     = commit_ertn;
    bus.redirect_valid = commit_ex || commit_ertn;
    bus.redirect_pc    = commit_ex ? bus.csr_eentry : (commit_ertn ? bus.csr_era : 32'd0);
    bus.flush_all      = commit_ex || commit_ertn || (state_q == DRAIN);
    bus.ws_commit_ok   = (state_q == IDLE) && bus.ws_valid && !cause_vld && !bus.ws_ertn;
  end

`ifdef EXC_PERF_CNT_EN
  logic [31:0] exc_cnt_q, exc_cnt_d;
  logic [31:0] ertn_cnt_q, ertn_cnt_d;

  always_comb begin
    exc_cnt_d  = exc_cnt_q + {31'd0, commit_ex};
    ertn_cnt_d = ertn_cnt_q + {31'd0, commit_ertn};
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      exc_cnt_q  <= 32'd0;
      ertn_cnt_q <= 32'd0;
    end else begin
      exc_cnt_q  <= exc_cnt_d;
      ertn_cnt_q <= ertn_cnt_d;
    end
  end

  assign exc_cnt  = exc_cnt_q;
  assign ertn_cnt = ertn_cnt_q;
`endif

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// tb/tb_exc_commit_ctrl.sv - scoreboard bench for exc_commit_ctrl; EXC_PERF_CNT_EN also checks the counters
module tb_exc_commit_ctrl;
  localparam int D = 2;

  typedef struct {
    bit        rstn;
    bit        valid;
    bit [31:0] pc;
    bit        adef, ine, sys, brk, ale;
    bit [31:0] vaddr;
    bit        ertn;
    bit        hint;
    bit [31:0] eentry;
    bit [31:0] era;
  } stim_t;

  typedef struct {
    bit        ex;
    bit [5:0]  ecode;
    bit [8:0]  subcode;
    bit [31:0] pc;
    bit [31:0] vaddr;
    bit        ertn;
    bit        rv;
    bit [31:0] rpc;
    bit        flush;
    bit        ok;
    bit [31:0] ecnt;
    bit [31:0] rcnt;
  } exp_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  exc_commit_ctrl_if bus();
`ifdef EXC_PERF_CNT_EN
  logic [31:0] exc_cnt, ertn_cnt;
  exc_commit_ctrl #(.DRAIN_CYCLES(D)) dut (.clk(clk), .resetn(resetn), .bus(bus),
                                           .exc_cnt(exc_cnt), .ertn_cnt(ertn_cnt));
`else
  exc_commit_ctrl #(.DRAIN_CYCLES(D)) dut (.clk(clk), .resetn(resetn), .bus(bus));
`endif

  int   total = 0;
  int   bad = 0;
  exp_t sb[$];

  // Reference: remaining drain cycles, plus event counts since reset.
  int        m_busy = 0;
  bit [31:0] m_ecnt = 0;
  bit [31:0] m_rcnt = 0;

  function automatic exp_t model(stim_t s);
    exp_t e;
    bit   is_ex;
    e = '{default: 0};
    e.ecnt = m_ecnt;
    e.rcnt = m_rcnt;
    is_ex = 0;
    if (m_busy > 0) begin
      e.flush = 1;
    end else if (s.valid) begin
      is_ex = 1;
      if (s.hint)      e.ecode = 6'h00;
      else if (s.adef) begin e.ecode = 6'h08; e.vaddr = s.pc; end
      else if (s.ine)  e.ecode = 6'h0D;
      else if (s.sys)  e.ecode = 6'h0B;
      else if (s.brk)  e.ecode = 6'h0C;
      else if (s.ale)  begin e.ecode = 6'h09; e.vaddr = s.vaddr; end
      else is_ex = 0;
      if (is_ex) begin
        e.ex = 1; e.pc = s.pc; e.rv = 1; e.rpc = s.eentry; e.flush = 1;
      end else if (s.ertn) begin
        e.ertn = 1; e.rv = 1; e.rpc = s.era; e.flush = 1;
      end else begin
        e.ok = 1;
      end
    end
    if (!s.rstn) begin
      m_busy = 0; m_ecnt = 0; m_rcnt = 0;
    end else begin
      if (m_busy > 0) m_busy--;
      else if (e.rv) m_busy = D;
      if (e.ex) m_ecnt++;
      if (e.ertn) m_rcnt++;
    end
    return e;
  endfunction

  function automatic stim_t blank();
    stim_t s;
    s = '{default: 0};
    s.rstn = 1;
    s.pc = 32'h1c000100;
    s.eentry = 32'h1c008000;
    s.era = 32'h1c000104;
    return s;
  endfunction

  task automatic step(input stim_t s);
    @(posedge clk);
    #1;
    resetn         = s.rstn;
    bus.ws_valid   = s.valid;
    bus.ws_pc      = s.pc;
    bus.ws_ex_adef = s.adef;
    bus.ws_ex_ine  = s.ine;
    bus.ws_ex_sys  = s.sys;
    bus.ws_ex_brk  = s.brk;
    bus.ws_ex_ale  = s.ale;
    bus.ws_vaddr   = s.vaddr;
    bus.ws_ertn    = s.ertn;
    bus.has_int    = s.hint;
    bus.csr_eentry = s.eentry;
    bus.csr_era    = s.era;
    sb.push_back(model(s));
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("wb_ex", 32'(bus.wb_ex), 32'(e.ex));
        chk("wb_ecode", 32'(bus.wb_ecode), 32'(e.ecode));
        chk("wb_esubcode", 32'(bus.wb_esubcode), 32'(e.subcode));
        chk("wb_pc", bus.wb_pc, e.pc);
        chk("wb_vaddr", bus.wb_vaddr, e.vaddr);
        chk("ertn_flush", 32'(bus.ertn_flush), 32'(e.ertn));
        chk("redirect_valid", 32'(bus.redirect_valid), 32'(e.rv));
        chk("redirect_pc", bus.redirect_pc, e.rpc);
        chk("flush_all", 32'(bus.flush_all), 32'(e.flush));
        chk("ws_commit_ok", 32'(bus.ws_commit_ok), 32'(e.ok));
`ifdef EXC_PERF_CNT_EN
        chk("exc_cnt", exc_cnt, e.ecnt);
        chk("ertn_cnt", ertn_cnt, e.rcnt);
`endif
      end
    end
  end

  initial begin
    stim_t s;
    bus.ws_valid = 0; bus.ws_pc = 0; bus.ws_ex_adef = 0; bus.ws_ex_ine = 0;
    bus.ws_ex_sys = 0; bus.ws_ex_brk = 0; bus.ws_ex_ale = 0; bus.ws_vaddr = 0;
    bus.ws_ertn = 0; bus.has_int = 0; bus.csr_eentry = 0; bus.csr_era = 0;
    repeat (2) @(posedge clk);
    s = blank(); s.rstn = 0; step(s);
    s = blank(); step(s);

    // single SYS, then idle through the drain
    s = blank(); s.valid = 1; s.sys = 1; step(s);
    repeat (3) step(blank());

    // priority: INT over ADEF/ALE, then ADEF over ALE
    s = blank(); s.valid = 1; s.hint = 1; s.adef = 1; s.ale = 1;
    s.pc = 32'h1c000203; s.vaddr = 32'h00000777; step(s);
    repeat (2) step(blank());
    s.hint = 0; step(s);
    repeat (2) step(blank());

    // ertn alone, then ertn with INE
    s = blank(); s.valid = 1; s.ertn = 1; step(s);
    repeat (2) step(blank());
    s.ine = 1; step(s);
    repeat (2) step(blank());

    // drain masking, clean commit right after the window
    s = blank(); s.valid = 1; s.sys = 1; step(s);
    s = blank(); s.valid = 1; s.brk = 1; step(s); step(s);
    s = blank(); s.valid = 1; step(s);

    // reset during drain
    s = blank(); s.valid = 1; s.ale = 1; s.vaddr = 32'hdeadbeef; step(s);
    s = blank(); s.rstn = 0; step(s);
    s = blank(); s.valid = 1; step(s);

    // pending interrupt without a committing instruction
    s = blank(); s.hint = 1;
    repeat (10) step(s);
    s.valid = 1; s.pc = 32'h1c000444; step(s);
    repeat (2) step(blank());

    for (int i = 0; i < 500; i++) begin
      s.rstn   = ($urandom % 60) != 0;
      s.valid  = s.rstn && (($urandom % 4) != 0);
      s.pc     = $urandom;
      s.adef   = ($urandom % 7) == 0;
      s.ine    = ($urandom % 7) == 0;
      s.sys    = ($urandom % 7) == 0;
      s.brk    = ($urandom % 7) == 0;
      s.ale    = ($urandom % 7) == 0;
      s.vaddr  = $urandom;
      s.ertn   = ($urandom % 5) == 0;
      s.hint   = ($urandom % 8) == 0;
      s.eentry = $urandom;
      s.era    = $urandom;
      step(s);
    end

    repeat (3) @(posedge clk);
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard_drain act=%0d exp=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
